// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter state type and baud-rate arithmetic
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_ser.sv
// uart_tx_ser: 8N1 serializer taking bytes over a valid/ready handshake
module uart_tx_ser
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       busy_o,
    output logic       tx_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    uart_tx_state_e state;
    logic [CW-1:0]  baud_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift;
    logic           bit_end;

    assign bit_end = baud_cnt == BAUD_LAST;
    // A byte is taken when idle or on the last stop-bit cycle, so frames run back to back
    assign ready_o = state == IDLE || (state == STOP && bit_end);
    assign busy_o  = state != IDLE;

    // Frame sequencing: baud timing, bit counting and data shifting
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            baud_cnt <= (state == IDLE || bit_end) ? '0 : baud_cnt + CW'(1);
            case (state)
                IDLE:  ;
                START: if (bit_end) state <= DATA;
                DATA: begin
                    if (bit_end) begin
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end
                end
                STOP:  if (bit_end) state <= IDLE;
            endcase
            if (valid_i && ready_o) begin
                state   <= START;
                shift   <= data_i;
                bit_cnt <= '0;
            end
        end
    end

    // Line driver registered from the state so tx_o never glitches
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) tx_o <= 1'b1;
        else         tx_o <= state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: byte FIFO feeding an 8N1 UART transmitter
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned QUEUE_LEN = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        valid_i,
    input  logic [7:0]                  data_i,
    output logic                        ready_o,
    output logic [$clog2(QUEUE_LEN):0]  level_o,
    output logic                        idle_o,
    output logic                        overflow_o,
    input  logic                        clear_ovf_i,
    output logic                        tx_o
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int AW = $clog2(QUEUE_LEN);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(QUEUE_LEN);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_buffered: CLK_FREQ / BAUD_RATE must be at least 2");
    end
    if (QUEUE_LEN < 2 || (QUEUE_LEN & (QUEUE_LEN - 1)) != 0) begin : g_bad_len
        $error("uart_tx_buffered: QUEUE_LEN must be a power of two and at least 2");
    end

    logic [7:0]    mem [QUEUE_LEN];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          push;
    logic          pop;
    logic          ser_ready;
    logic          ser_busy;

    // Flow control depends only on the registered count, never on valid_i
    assign ready_o = count != FULL;
    assign push    = valid_i && ready_o;
    assign pop     = count != '0 && ser_ready;
    assign level_o = count;
    assign idle_o  = !ser_busy && count == '0;

    // Queue storage is left unreset; count guards every read
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= data_i;
    end

    // Pointers wrap naturally at QUEUE_LEN; overflow set takes priority over clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + LW'(push) - LW'(pop);
            if (valid_i && !ready_o) overflow_o <= 1'b1;
            else if (clear_ovf_i)    overflow_o <= 1'b0;
        end
    end

    uart_tx_ser #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (pop),
        .data_i  (mem[rd_ptr]),
        .ready_o (ser_ready),
        .busy_o  (ser_busy),
        .tx_o    (tx_o)
    );

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: vector table, directed corner cases and random traffic against a line-timing model
module tb_uart_tx_buffered;

    localparam int QL = 8;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       valid_i = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       clear_ovf_i = 1'b0;
    logic       ready_o;
    logic [3:0] level_o;
    logic       idle_o;
    logic       overflow_o;
    logic       tx_o;

    int n_chk = 0;
    int n_fail = 0;
    int max_lvl = 0;

    // Reference model: queue contents plus the edge at which the line last began a frame
    logic [7:0] m_q[$];
    logic [7:0] m_cur = 8'h00;
    logic       m_ovf = 1'b0;
    int         m_last = -1000;
    int         m_free = 0;
    int         e = 0;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       clr;
        int         lvl;
        logic       rdy;
        logic       ovf;
    } vec_t;

    vec_t tbl[13];

    uart_tx_buffered #(
        .CLK_FREQ  (1_000_000),
        .BAUD_RATE (100_000),
        .QUEUE_LEN (QL)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .valid_i     (valid_i),
        .data_i      (data_i),
        .ready_o     (ready_o),
        .level_o     (level_o),
        .idle_o      (idle_o),
        .overflow_o  (overflow_o),
        .clear_ovf_i (clear_ovf_i),
        .tx_o        (tx_o)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf  = 1'b0;
        m_last = -1000;
        m_free = 0;
    endtask

    // One clock: drive inputs, advance the model across the edge, compare at the falling edge
    task automatic tick(input logic v, input logic [7:0] d, input logic c);
        logic       full;
        logic [9:0] fr;
        int         off;
        valid_i = v;
        data_i = d;
        clear_ovf_i = c;
        @(posedge clk);
        full = m_q.size() == QL;
        if (m_q.size() != 0 && e >= m_free) begin
            m_cur  = m_q.pop_front();
            m_last = e;
            m_free = e + 100;
        end
        if (v && !full) m_q.push_back(d);
        m_ovf = (v && full) ? 1'b1 : c ? 1'b0 : m_ovf;
        off = e - 1 - m_last;
        fr = {1'b1, m_cur, 1'b0};
        @(negedge clk);
        valid_i = 1'b0;
        clear_ovf_i = 1'b0;
        check("tx", tx_o, (off >= 0 && off < 100) ? fr[off / 10] : 1'b1);
        check("level", level_o, m_q.size());
        check("ready", ready_o, m_q.size() != QL);
        check("idle", idle_o, m_q.size() == 0 && e >= m_free);
        check("overflow", overflow_o, m_ovf);
        if (int'(level_o) > max_lvl) max_lvl = level_o;
        e++;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && !idle_o; i++) tick(1'b0, 8'h00, 1'b0);
        check("drain_idle", idle_o, 1'b1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_tx"}, tx_o, 1'b1);
        check({tag, "_level"}, level_o, 0);
        check({tag, "_ready"}, ready_o, 1'b1);
        check({tag, "_idle"}, idle_o, 1'b1);
        check({tag, "_ovf"}, overflow_o, 1'b0);
    endtask

    initial begin
        logic       txs [103];
        logic       ids [103];
        logic [7:0] b;
        int         c;
        int         ones;
        int         pushes;

        tbl[0] = '{1'b1, 8'hA0, 1'b0, 1, 1'b1, 1'b0};
        for (int i = 1; i <= 8; i++) tbl[i] = '{1'b1, 8'hA0 + 8'(i), 1'b0, i, i != 8, 1'b0};
        tbl[9]  = '{1'b1, 8'hA9, 1'b0, 8, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 8, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 8'hAB, 1'b1, 8, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 8, 1'b0, 1'b0};

        @(negedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst_ni = 1'b1;

        b = 8'hA5;
        tick(1'b1, b, 1'b0);
        for (int i = 1; i <= 102; i++) begin
            tick(1'b0, 8'h00, 1'b0);
            txs[i] = tx_o;
            ids[i] = idle_o;
        end
        check("a5_pre_start", txs[1], 1'b1);
        check("a5_start_first", txs[2], 1'b0);
        check("a5_start_last", txs[11], 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("a5_bit_first", txs[12 + 10 * i], b[i]);
            check("a5_bit_last", txs[21 + 10 * i], b[i]);
        end
        check("a5_stop_first", txs[92], 1'b1);
        check("a5_stop_last", txs[101], 1'b1);
        check("a5_busy", ids[90], 1'b0);
        check("a5_idle", ids[102], 1'b1);

        max_lvl = 0;
        tick(1'b1, 8'h00, 1'b0);
        tick(1'b1, 8'hFF, 1'b0);
        tick(1'b1, 8'h55, 1'b0);
        c = 2;
        ones = tx_o;
        while (!idle_o && c < 1000) begin
            tick(1'b0, 8'h00, 1'b0);
            c++;
            if (c <= 301) ones += tx_o;
        end
        check("burst_idle_edge", c, 301);
        check("burst_high_cycles", ones, 150);
        check("burst_peak_level", max_lvl, 2);

        for (int i = 0; i < 13; i++) begin
            tick(tbl[i].v, tbl[i].d, tbl[i].clr);
            check("tbl_level", level_o, tbl[i].lvl);
            check("tbl_ready", ready_o, tbl[i].rdy);
            check("tbl_ovf", overflow_o, tbl[i].ovf);
        end
        drain();

        tick(1'b1, 8'h11, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b1, 8'h22, 1'b0);
        for (int i = 3; i <= 100; i++) tick(1'b0, 8'h00, 1'b0);
        check("simul_pre_level", level_o, 1);
        tick(1'b1, 8'h33, 1'b0);
        check("simul_level", level_o, 1);
        check("simul_stop_tail", tx_o, 1'b1);
        tick(1'b0, 8'h00, 1'b0);
        check("simul_next_start", tx_o, 1'b0);
        drain();

        pushes = 0;
        for (int i = 0; i < 4000 && pushes < 20; i++) begin
            if (ready_o && $urandom_range(0, 40) == 0) begin
                tick(1'b1, 8'($urandom), 1'b0);
                pushes++;
            end else begin
                tick(1'b0, 8'h00, 1'b0);
            end
        end
        check("wrap_pushes", pushes, 20);
        drain();

        for (int i = 0; i < 3000; i++)
            tick($urandom_range(0, 29) == 0, 8'($urandom), $urandom_range(0, 49) == 0);
        drain();

        tick(1'b1, 8'h3C, 1'b0);
        tick(1'b1, 8'h77, 1'b0);
        for (int i = 2; i <= 45; i++) tick(1'b0, 8'h00, 1'b0);
        check("pre_rst_level", level_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_state("mid_rst");
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        tick(1'b1, 8'h81, 1'b0);
        drain();

        tick(1'b1, 8'hC3, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        check("start_rst_pre_tx", tx_o, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_state("start_rst");
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        tick(1'b0, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, is the clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, is the line rate in bit/s.
REQ-003 Parameter QUEUE_LEN, default 8, is the TX queue depth in bytes; it SHALL be a power of two and at least 2.
REQ-004 Port clk_i, input, 1 bit: the single clock; all logic SHALL run on its rising edge.
REQ-005 Port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port valid_i, input, 1 bit: a write byte is present.
REQ-007 Port data_i, input, 8 bits: the write byte.
REQ-008 Port ready_o, output, 1 bit: the queue can accept a byte.
REQ-009 Port level_o, output, $clog2(QUEUE_LEN)+1 bits: the number of queued bytes, excluding the byte on the line.
REQ-010 Port idle_o, output, 1 bit: the queue is empty and no frame is in progress.
REQ-011 Port overflow_o, output, 1 bit: sticky flag, a write was dropped.
REQ-012 Port clear_ovf_i, input, 1 bit: clears overflow_o.
REQ-013 Port tx_o, output, 1 bit: the serial line, high when idle.

Function
REQ-014 CLKS_PER_BIT SHALL be CLK_FREQ / BAUD_RATE (integer truncation); elaboration SHALL fail if CLKS_PER_BIT < 2.
REQ-015 Frame format SHALL be: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit held exactly CLKS_PER_BIT cycles; no parity.
REQ-016 A push SHALL occur in any cycle with valid_i && ready_o; the byte is visible in level_o the next cycle.
REQ-017 ready_o SHALL equal (level_o != QUEUE_LEN), registered-count based, with no combinational path from valid_i.
REQ-018 valid_i while full SHALL drop the byte, leave the queue unchanged, and set overflow_o on the next cycle.
REQ-019 clear_ovf_i SHALL clear overflow_o next cycle; if it coincides with an overflow, set wins.
REQ-020 Serializer FSM states SHALL be IDLE, START, DATA, STOP.
REQ-021 IDLE with queue non-empty: pop the head, go to START; tx_o low from the next cycle.
REQ-022 START -> DATA after CLKS_PER_BIT cycles; DATA -> STOP after 8 bits; STOP lasts CLKS_PER_BIT cycles.
REQ-023 At STOP end: if the queue is non-empty, pop and go directly to START (no idle cycle between frames); otherwise go to IDLE.
REQ-024 Latency: byte pushed into an empty, idle block at edge k SHALL drive the start bit on tx_o from edge k+2.
REQ-025 Simultaneous push and pop SHALL leave level_o unchanged; the FIFO read/write pointers SHALL wrap modulo QUEUE_LEN.
REQ-026 tx_o SHALL be driven from a flop (glitch-free).
REQ-027 idle_o SHALL be high only in IDLE with level_o == 0.

Reset
REQ-028 On rst_ni low, the block SHALL asynchronously reach:
- tx_o = 1
- FSM = IDLE
- queue emptied, level_o = 0
- ready_o = 1, idle_o = 1, overflow_o = 0
REQ-029 Reset mid-frame SHALL abort the frame immediately: tx_o returns high and queued bytes are lost.
REQ-030 Queue storage contents need no reset.

Structure
REQ-031 A shared package uart_pkg SHALL hold the uart_tx_state_e enum (IDLE/START/DATA/STOP) and a clks_per_bit(CLK_FREQ, BAUD_RATE) function.
REQ-032 The block SHALL consist of:
- a FIFO (storage, pointers, count) in the top module;
- one sub-module uart_tx_ser containing the FSM, bit counter, baud counter and shift register, with a valid/ready byte input.

Verification (CLK_FREQ=1_000_000, BAUD_RATE=100_000, CLKS_PER_BIT=10)
REQ-033 Single byte: push 0xA5 at edge 0 -> tx_o low on cycles 2-11, then 1,0,1,0,0,1,0,1 for 10 cycles each, then high for 10 cycles; idle_o high at cycle 102.
REQ-034 Burst: push 0x00,0xFF,0x55 back-to-back -> three contiguous 100-cycle frames with no idle gap; level_o peaks at 2.
REQ-035 Overflow: 1 in flight plus 8 queued (level_o=8), 9th push -> ready_o=0, byte dropped, overflow_o=1 next cycle; clear_ovf_i -> 0.
REQ-036 Wrap: 20 pushes while draining, pointers wrapping -> bytes emitted in push order, no loss.
REQ-037 Reset mid-frame: rst_ni low during bit 3 of 0x3C -> tx_o high within the same cycle, level_o=0; after release, push 0x81 -> a correct frame.
REQ-038 Simultaneous push/pop at STOP end with level_o=1 -> level_o stays 1 and the next frame starts immediately.
